// File: rtl/uart_xfer_pkg.sv
// Shared types and default constants for the UART image transfer controller.
package uart_xfer_pkg;

  localparam int BYTES_PER_WORD      = 4;
  localparam int DEF_WORDS_PER_IMAGE = 25344;
  localparam int DEF_SRC_BASE        = 0;
  localparam int DEF_DST_BASE        = 25344;

  typedef enum logic [2:0] {
    XFER_IDLE      = 3'd0,
    XFER_RX_LOAD   = 3'd1,
    XFER_ACC_START = 3'd2,
    XFER_ACC_WAIT  = 3'd3,
    XFER_TX_READ   = 3'd4,
    XFER_TX_WAIT   = 3'd5,
    XFER_TX_BYTE   = 3'd6,
    XFER_DONE      = 3'd7
  } xfer_state_t;

endpackage

// File: rtl/uart_img_xfer_ctrl_if.sv
// Bundle of UART byte stream, image RAM port and accelerator handshake signals.
interface uart_img_xfer_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_stb;
  logic [7:0]        tx_data;
  logic              tx_stb;
  logic              tx_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              acc_start;
  logic              acc_finish;
  logic              busy;
  logic              rx_err;

  modport master (
    input  rx_data, rx_stb, tx_ack, mem_rdata, acc_finish,
    output tx_data, tx_stb, mem_en, mem_we, mem_addr, mem_wdata, acc_start, busy, rx_err
  );

  modport slave (
    output rx_data, rx_stb, tx_ack, mem_rdata, acc_finish,
    input  tx_data, tx_stb, mem_en, mem_we, mem_addr, mem_wdata, acc_start, busy, rx_err
  );
endinterface

// File: rtl/xfer_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid pulses the cycle after byte 3.
module xfer_byte_packer
  import uart_xfer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_stb,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      asm_q, asm_d;
  logic             vld_q, vld_d;

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    vld_d = 1'b0;
    if (clear) begin
      idx_d = '0;
      asm_d = '0;
    end else if (byte_stb) begin
      asm_d[8*idx_q +: 8] = byte_data;
      if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
        vld_d = 1'b1;
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= '0;
      vld_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      vld_q <= vld_d;
    end
  end

  // A byte landing during the write cycle only alters asm_q after the word has been written.
  assign word_valid = vld_q;
  assign word_data  = asm_q;

endmodule

// File: rtl/uart_img_xfer_ctrl.sv
// Loads an image over UART into RAM, kicks the accelerator, then streams the result back.
// Optional build macro RX_TIMEOUT_EN: abort a stalled image load and raise rx_err.
module uart_img_xfer_ctrl
  import uart_xfer_pkg::*;
#(
  parameter int WORDS_PER_IMAGE   = DEF_WORDS_PER_IMAGE,
  parameter int SRC_BASE          = DEF_SRC_BASE,
  parameter int DST_BASE          = DEF_DST_BASE,
  parameter int ADDR_W            = 16,
  parameter int RX_TIMEOUT_CYCLES = 10_000_000
) (
  input logic                  clk,
  input logic                  rst,
  uart_img_xfer_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE      = XFER_IDLE;
  localparam logic [2:0] S_RX_LOAD   = XFER_RX_LOAD;
  localparam logic [2:0] S_ACC_START = XFER_ACC_START;
  localparam logic [2:0] S_ACC_WAIT  = XFER_ACC_WAIT;
  localparam logic [2:0] S_TX_READ   = XFER_TX_READ;
  localparam logic [2:0] S_TX_WAIT   = XFER_TX_WAIT;
  localparam logic [2:0] S_TX_BYTE   = XFER_TX_BYTE;
  localparam logic [2:0] S_DONE      = XFER_DONE;

  localparam int              WIDX_W    = $clog2(WORDS_PER_IMAGE + 1);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_IMAGE - 1);

  logic [2:0]        state_q, state_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        tx_byte_q, tx_byte_d;
  logic [31:0]       tx_word_q, tx_word_d;
  logic              rx_err_q, rx_err_d;

  logic        in_load, wr_en, timeout;
  logic        word_valid;
  logic [31:0] word_data;

  assign in_load = (state_q == S_IDLE) || (state_q == S_RX_LOAD);
  assign wr_en   = word_valid && (state_q == S_RX_LOAD);

  xfer_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (!in_load || timeout),
    .byte_stb   (in_load && bus.rx_stb),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

`ifdef RX_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == S_RX_LOAD) && !bus.rx_stb) idle_cnt_d = idle_cnt_q + 32'd1;
  end

  assign timeout = (state_q == S_RX_LOAD) && !bus.rx_stb &&
                   (idle_cnt_q == 32'(RX_TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^32'(RX_TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_word_d  = tx_word_q;
    rx_err_d   = rx_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_stb) begin
          state_d    = S_RX_LOAD;
          word_idx_d = '0;
          rx_err_d   = 1'b0;
        end
      end
      S_RX_LOAD: begin
        if (timeout) begin
          state_d    = S_IDLE;
          word_idx_d = '0;
          rx_err_d   = 1'b1;
        end else if (word_valid) begin
          if (word_idx_q == LAST_WORD) begin
            state_d    = S_ACC_START;
            word_idx_d = '0;
          end else begin
            word_idx_d = word_idx_q + WIDX_W'(1);
          end
        end
      end
      S_ACC_START: state_d = S_ACC_WAIT;
      S_ACC_WAIT:  if (bus.acc_finish) state_d = S_TX_READ;
      S_TX_READ:   state_d = S_TX_WAIT;
      S_TX_WAIT: begin
        tx_word_d = bus.mem_rdata;
        tx_byte_d = '0;
        state_d   = S_TX_BYTE;
      end
      S_TX_BYTE: begin
        if (bus.tx_ack) begin
          if (tx_byte_q == 2'd3) begin
            if (word_idx_q == LAST_WORD) begin
              state_d    = S_DONE;
              word_idx_d = '0;
            end else begin
              state_d    = S_TX_READ;
              word_idx_d = word_idx_q + WIDX_W'(1);
            end
          end else begin
            tx_byte_d = tx_byte_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        word_idx_d = '0;
        tx_byte_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      tx_byte_q  <= '0;
      tx_word_q  <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_word_q  <= tx_word_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign bus.mem_en    = wr_en || (state_q == S_TX_READ);
  assign bus.mem_we    = wr_en;
  assign bus.mem_addr  = ((state_q == S_TX_READ) ? ADDR_W'(DST_BASE) : ADDR_W'(SRC_BASE)) +
                         ADDR_W'(word_idx_q);
  assign bus.mem_wdata = wr_en ? word_data : 32'd0;
  assign bus.acc_start = (state_q == S_ACC_START);
  assign bus.tx_stb    = (state_q == S_TX_BYTE);
  assign bus.tx_data   = bus.tx_stb ? tx_word_q[8*tx_byte_q +: 8] : 8'd0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rx_err    = rx_err_q;

endmodule

// File: tb/tb_uart_img_xfer_ctrl.sv
// Scoreboard bench for uart_img_xfer_ctrl with a 1-cycle-latency RAM model.
module tb_uart_img_xfer_ctrl;

  localparam int WORDS  = 4;
  localparam int SRC    = 0;
  localparam int DST    = 16;
  localparam int AW     = 16;
  localparam int TO_CYC = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_img_xfer_ctrl_if #(.ADDR_W(AW)) bus_if ();

  uart_img_xfer_ctrl #(
    .WORDS_PER_IMAGE   (WORDS),
    .SRC_BASE          (SRC),
    .DST_BASE          (DST),
    .ADDR_W            (AW),
    .RX_TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [7:0]    exp_tx_q[$];

  function automatic logic [31:0] dst_word(input logic [AW-1:0] j);
    return 32'hAABBCCDD ^ {4{j[7:0]}};
  endfunction

  // RAM model: source region is a plain array, result region is a fixed pattern.
  logic [31:0] ram [0:31];
  always @(posedge clk) begin
    if (bus_if.mem_en && bus_if.mem_we) ram[bus_if.mem_addr[4:0]] <= bus_if.mem_wdata;
    if (bus_if.mem_en && !bus_if.mem_we)
      bus_if.mem_rdata <= (bus_if.mem_addr >= AW'(DST)) ? dst_word(bus_if.mem_addr - AW'(DST))
                                                       : ram[bus_if.mem_addr[4:0]];
  end

  logic [AW-1:0] mon_a;
  logic [31:0]   mon_d;
  always @(negedge clk) begin
    if (!rst && bus_if.mem_en && bus_if.mem_we) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        failures++;
        $display("FAIL mem_write unexpected: addr=%0h data=%h, required no write",
                 bus_if.mem_addr, bus_if.mem_wdata);
      end else begin
        mon_a = exp_addr_q.pop_front();
        mon_d = exp_data_q.pop_front();
        if (bus_if.mem_addr !== mon_a || bus_if.mem_wdata !== mon_d) begin
          failures++;
          $display("FAIL mem_write got addr=%0h data=%h, required addr=%0h data=%h",
                   bus_if.mem_addr, bus_if.mem_wdata, mon_a, mon_d);
        end
      end
    end
    if (!rst && bus_if.acc_start) acc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data = b;
    bus_if.rx_stb  = 1'b1;
    @(negedge clk);
    bus_if.rx_stb  = 1'b0;
  endtask

  task automatic push_image(input logic [7:0] base);
    for (int w = 0; w < WORDS; w++) begin
      logic [7:0] b0;
      b0 = base + 8'(4 * w);
      exp_addr_q.push_back(AW'(SRC + w));
      exp_data_q.push_back({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end
  endtask

  task automatic wait_acc_start(input int prev, input string name);
    int n;
    n = 0;
    while (acc_cnt == prev && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (acc_cnt !== prev + 1) begin
      failures++;
      $display("FAIL %s acc_start pulses got=%0d required=%0d", name, acc_cnt - prev, 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (acc_cnt !== prev + 1) begin
      failures++;
      $display("FAIL %s acc_start single pulse got=%0d required=%0d", name, acc_cnt - prev, 1);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending writes got=%0d required=0", name, exp_addr_q.size());
    end
    checks++;
    if (bus_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_in_acc_wait got=%b required=1", name, bus_if.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b required=0", bus_if.busy); end
    checks++; if (bus_if.mem_en !== 1'b0)     begin failures++; $display("FAIL rst_mem_en got=%b required=0", bus_if.mem_en); end
    checks++; if (bus_if.mem_we !== 1'b0)     begin failures++; $display("FAIL rst_mem_we got=%b required=0", bus_if.mem_we); end
    checks++; if (bus_if.mem_addr !== '0)     begin failures++; $display("FAIL rst_mem_addr got=%h required=0", bus_if.mem_addr); end
    checks++; if (bus_if.mem_wdata !== '0)    begin failures++; $display("FAIL rst_mem_wdata got=%h required=0", bus_if.mem_wdata); end
    checks++; if (bus_if.tx_stb !== 1'b0)     begin failures++; $display("FAIL rst_tx_stb got=%b required=0", bus_if.tx_stb); end
    checks++; if (bus_if.tx_data !== 8'h00)   begin failures++; $display("FAIL rst_tx_data got=%h required=00", bus_if.tx_data); end
    checks++; if (bus_if.acc_start !== 1'b0)  begin failures++; $display("FAIL rst_acc_start got=%b required=0", bus_if.acc_start); end
    checks++; if (bus_if.rx_err !== 1'b0)     begin failures++; $display("FAIL rst_rx_err got=%b required=0", bus_if.rx_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load(input logic [7:0] base);
    int prev;
    prev = acc_cnt;
    push_image(base);
    for (int i = 0; i < 4 * WORDS; i++) send_byte(base + 8'(i));
    wait_acc_start(prev, "load");
  endtask

  task automatic test_acc_and_tx();
    int n;
    logic [31:0] w;
    logic [7:0]  exp;
    logic [7:0]  seen;
    logic        stable;
    send_byte(8'h55);
    bus_if.tx_ack = 1'b1;
    @(negedge clk);
    bus_if.tx_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.tx_stb !== 1'b0) begin
      failures++;
      $display("FAIL acc_wait_tx_stb got=%b required=0", bus_if.tx_stb);
    end
    bus_if.acc_finish = 1'b1;
    @(negedge clk);
    bus_if.acc_finish = 1'b0;
    for (int j = 0; j < WORDS; j++) begin
      w = dst_word(AW'(j));
      for (int k = 0; k < 4; k++) exp_tx_q.push_back(w[8*k +: 8]);
    end
    for (int i = 0; i < 4 * WORDS; i++) begin
      n = 0;
      while (!bus_if.tx_stb && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus_if.tx_stb !== 1'b1) begin
        failures++;
        $display("FAIL tx_stb_wait byte=%0d got=%b required=1", i, bus_if.tx_stb);
      end
      if (i % 4 == 0 && i > 0) begin
        checks++;
        if (n != 2) begin
          failures++;
          $display("FAIL tx_word_gap byte=%0d got=%0d required=2", i, n);
        end
      end
      exp    = exp_tx_q.pop_front();
      stable = 1'b1;
      seen   = bus_if.tx_data;
      for (int c = 0; c < 20; c++) begin
        if (bus_if.tx_data !== exp || bus_if.tx_stb !== 1'b1) begin
          stable = 1'b0;
          seen   = bus_if.tx_data;
        end
        if (i == 5 && c == 3) send_byte(8'h55);
        else @(negedge clk);
      end
      checks++;
      if (!stable) begin
        failures++;
        $display("FAIL tx_byte idx=%0d got=%h required=%h (held until ack)", i, seen, exp);
      end
      bus_if.tx_ack = 1'b1;
      @(negedge clk);
      bus_if.tx_ack = 1'b0;
      checks++;
      if (bus_if.tx_stb !== ((i % 4) != 3)) begin
        failures++;
        $display("FAIL tx_stb_after_ack idx=%0d got=%b required=%b", i, bus_if.tx_stb, (i % 4) != 3);
      end
    end
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_done got=%b required=0", bus_if.busy);
    end
  endtask

  task automatic test_reset_mid();
    exp_addr_q.push_back(AW'(SRC));
    exp_data_q.push_back(32'hF3F2F1F0);
    for (int i = 0; i < 6; i++) send_byte(8'hF0 + 8'(i));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.mem_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b mem_en=%b required 0 0", bus_if.busy, bus_if.mem_en);
    end
    rst = 1'b0;
    @(negedge clk);
    test_load(8'h20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_end busy got=%b required=0", bus_if.busy);
    end
  endtask

`ifdef RX_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int prev;
    exp_addr_q.push_back(AW'(SRC));
    exp_data_q.push_back(32'h33323130);
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
    repeat (90) @(negedge clk);
    checks++;
    if (bus_if.rx_err !== 1'b0 || bus_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early got rx_err=%b busy=%b required 0 1", bus_if.rx_err, bus_if.busy);
    end
    n = 90;
    while (bus_if.rx_err !== 1'b1 && n < 130) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TO_CYC) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d required=%0d", n, TO_CYC);
    end
    checks++;
    if (bus_if.rx_err !== 1'b1 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_flag got rx_err=%b busy=%b required 1 0", bus_if.rx_err, bus_if.busy);
    end
    prev = acc_cnt;
    push_image(8'h40);
    send_byte(8'h40);
    checks++;
    if (bus_if.rx_err !== 1'b0 || bus_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_clear got rx_err=%b busy=%b required 0 1", bus_if.rx_err, bus_if.busy);
    end
    for (int i = 1; i < 4 * WORDS; i++) send_byte(8'h40 + 8'(i));
    wait_acc_start(prev, "timeout_reload");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst               = 1'b1;
    bus_if.rx_data    = 8'h00;
    bus_if.rx_stb     = 1'b0;
    bus_if.tx_ack     = 1'b0;
    bus_if.acc_finish = 1'b0;
    test_reset();
    test_load(8'h00);
    test_acc_and_tx();
    test_load(8'h80);
    test_acc_and_tx();
    test_reset_mid();
`ifdef RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
